tx_engine: RTL

- Transmit-side counterpart of the receive descriptor engine in the e1000 datapath.
- Takes local addresses of legacy TX descriptors that have already been copied into local descriptor RAM.
- For each descriptor: fetches it over AXI, DMAs the host buffer into a local packet slot through iDMA, and assembles multi-descriptor frames up to EOP.
- Hands each completed frame to frame process, writes DD back into the descriptor when RS is set, and reports completion.

---
 rtl/tx_engine.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/tx_engine.sv
// tx_engine: transmit descriptor engine.
// Takes local addresses of legacy TX descriptors on cmd_s. For each one it
// fetches the 16-byte descriptor over the AXI3 read port. It then asks iDMA
// to copy the host buffer into the current packet slot, and closes the frame
// on EOP by sending {length, slot address} on frm_m. When RS is set it writes
// DD back through the AXI3 write port. Every descriptor ends with a status
// beat on stat_m.
// Ports:
//   aclk, aresetn            clock, asynchronous active-low reset
//   cmd_s_*                  descriptor address in ([15:0])
//   stat_m_*                 status out {EOP, DD written, address}
//   ram_m_ar*/r*, aw*/w*/b*  AXI3 master to local descriptor RAM
//   dma_*                    host-to-local copy request
//   rpt_*                    copy completion
//   frm_m_*                  finished frame {length, slot start address}
//   frm_s_*                  slot-release tokens (one credit per beat)
module tx_engine #(
  parameter logic [15:0] BUF_BASE   = 16'h8000,
  parameter int unsigned SLOT_BYTES = 2048,
  parameter int unsigned NSLOT      = 8
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [31:0] cmd_s_tdata,
  input  logic        cmd_s_tvalid,
  input  logic        cmd_s_tlast,
  output logic        cmd_s_tready,
  output logic [31:0] stat_m_tdata,
  output logic        stat_m_tvalid,
  output logic        stat_m_tlast,
  input  logic        stat_m_tready,
  output logic [3:0]  ram_m_arid,
  output logic [15:0] ram_m_araddr,
  output logic [7:0]  ram_m_arlen,
  output logic [2:0]  ram_m_arsize,
  output logic [1:0]  ram_m_arburst,
  output logic        ram_m_arvalid,
  input  logic        ram_m_arready,
  input  logic [3:0]  ram_m_rid,
  input  logic [31:0] ram_m_rdata,
  input  logic [1:0]  ram_m_rresp,
  input  logic        ram_m_rlast,
  input  logic        ram_m_rvalid,
  output logic        ram_m_rready,
  output logic [3:0]  ram_m_awid,
  output logic [15:0] ram_m_awaddr,
  output logic [7:0]  ram_m_awlen,
  output logic [2:0]  ram_m_awsize,
  output logic [1:0]  ram_m_awburst,
  output logic        ram_m_awvalid,
  input  logic        ram_m_awready,
  output logic [3:0]  ram_m_wid,
  output logic [31:0] ram_m_wdata,
  output logic [3:0]  ram_m_wstrb,
  output logic        ram_m_wlast,
  output logic        ram_m_wvalid,
  input  logic        ram_m_wready,
  input  logic [3:0]  ram_m_bid,
  input  logic [1:0]  ram_m_bresp,
  input  logic        ram_m_bvalid,
  output logic        ram_m_bready,
  output logic [63:0] dma_src_addr,
  output logic [15:0] dma_dst_addr,
  output logic [15:0] dma_bytes,
  output logic        dma_valid,
  input  logic        dma_ready,
  input  logic [63:0] rpt_src_addr,
  input  logic [15:0] rpt_dst_addr,
  input  logic [15:0] rpt_bytes,
  input  logic        rpt_valid,
  output logic        rpt_ready,
  output logic [31:0] frm_m_tdata,
  output logic        frm_m_tvalid,
  output logic        frm_m_tlast,
  input  logic        frm_m_tready,
  input  logic [31:0] frm_s_tdata,
  input  logic        frm_s_tvalid,
  input  logic        frm_s_tlast,
  output logic        frm_s_tready
);

  localparam int unsigned SLOT_W = $clog2(NSLOT);
  localparam int unsigned CNT_W  = $clog2(NSLOT + 1);

  typedef enum logic [3:0] {
    IDLE, FETCH_A, FETCH_D, SLOT, DMA_REQ, DMA_WAIT, EOPCHK,
    FRAME, WB_CHK, WB_A, WB_D, WB_B, REPORT
  } state_t;

  state_t state, state_nx;

  logic [15:0]       desc_addr;
  logic [1:0]        beat;
  logic [31:0]       dw [4];
  logic [CNT_W-1:0]  free_cnt;
  logic [SLOT_W-1:0] slot_idx;
  logic [15:0]       slot_base;
  logic [15:0]       frm_len;
  logic              in_frame;

  logic              eop, rs;
  logic [63:0]       host_addr;
  logic [16:0]       room_c;
  logic [15:0]       cur_bytes_c;
  logic              go_c, claim_c, ret_c, frame_done_c;

  // Fixed AXI attributes and always-ready sinks.
  assign ram_m_arid    = 4'd0;
  assign ram_m_arlen   = 8'd3;
  assign ram_m_arsize  = 3'b010;
  assign ram_m_arburst = 2'b01;
  assign ram_m_rready  = 1'b1;
  assign ram_m_awid    = 4'd0;
  assign ram_m_awlen   = 8'd0;
  assign ram_m_awsize  = 3'b010;
  assign ram_m_awburst = 2'b01;
  assign ram_m_wid     = 4'd0;
  assign ram_m_wstrb   = 4'hF;
  assign ram_m_wlast   = 1'b1;
  assign ram_m_bready  = 1'b1;
  assign rpt_ready     = 1'b1;
  assign frm_s_tready  = 1'b1;
  assign stat_m_tlast  = 1'b1;
  assign frm_m_tlast   = 1'b1;

  // Descriptor fields and payloads taken straight from holding registers.
  assign eop          = dw[2][24];
  assign rs           = dw[2][27];
  assign host_addr    = {dw[1], dw[0]};
  assign ram_m_araddr = desc_addr;
  assign ram_m_awaddr = {desc_addr[15:4], 4'hC};
  assign ram_m_wdata  = {dw[3][31:1], 1'b1};
  assign dma_src_addr = host_addr;
  assign frm_m_tdata  = {frm_len, slot_base};
  assign stat_m_tdata = {14'd0, eop, rs, desc_addr};

  // Clip the copy to the space left in the slot; the excess is dropped.
  always_comb begin
    room_c       = 17'(SLOT_BYTES) - {1'b0, frm_len};
    cur_bytes_c  = ({1'b0, dw[2][15:0]} < room_c) ? dw[2][15:0] : room_c[15:0];
    go_c         = in_frame || (free_cnt != '0);
    claim_c      = (state == SLOT) && !in_frame && (free_cnt != '0);
    ret_c        = frm_s_tvalid;
    frame_done_c = (state == FRAME) && frm_m_tready;
  end

  // State register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:     if (cmd_s_tvalid && cmd_s_tlast) state_nx = FETCH_A;
      FETCH_A:  if (ram_m_arready) state_nx = FETCH_D;
      FETCH_D:  if (ram_m_rvalid && ram_m_rlast) state_nx = SLOT;
      SLOT:     if (go_c) state_nx = (cur_bytes_c == '0 || host_addr == '0) ? EOPCHK : DMA_REQ;
      DMA_REQ:  if (dma_ready) state_nx = DMA_WAIT;
      DMA_WAIT: if (rpt_valid) state_nx = EOPCHK;
      EOPCHK:   state_nx = eop ? FRAME : WB_CHK;
      FRAME:    if (frm_m_tready) state_nx = WB_CHK;
      WB_CHK:   state_nx = rs ? WB_A : REPORT;
      WB_A:     if (ram_m_awready) state_nx = WB_D;
      WB_D:     if (ram_m_wready) state_nx = WB_B;
      WB_B:     if (ram_m_bvalid) state_nx = REPORT;
      REPORT:   if (stat_m_tready) state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  // Handshake strobes registered from the next state; datapath registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cmd_s_tready  <= 1'b1;
      ram_m_arvalid <= 1'b0;
      dma_valid     <= 1'b0;
      frm_m_tvalid  <= 1'b0;
      ram_m_awvalid <= 1'b0;
      ram_m_wvalid  <= 1'b0;
      stat_m_tvalid <= 1'b0;
      desc_addr     <= '0;
      beat          <= '0;
      dw            <= '{default: '0};
      dma_dst_addr  <= '0;
      dma_bytes     <= '0;
      free_cnt      <= CNT_W'(NSLOT);
      slot_idx      <= '0;
      slot_base     <= BUF_BASE;
      frm_len       <= '0;
      in_frame      <= 1'b0;
    end else begin
      cmd_s_tready  <= (state_nx == IDLE);
      ram_m_arvalid <= (state_nx == FETCH_A);
      dma_valid     <= (state_nx == DMA_REQ);
      frm_m_tvalid  <= (state_nx == FRAME);
      ram_m_awvalid <= (state_nx == WB_A);
      ram_m_wvalid  <= (state_nx == WB_D);
      stat_m_tvalid <= (state_nx == REPORT);

      if (state == IDLE && cmd_s_tvalid && cmd_s_tlast) begin
        desc_addr <= cmd_s_tdata[15:0];
        beat      <= '0;
      end
      if (state == FETCH_D && ram_m_rvalid) begin
        dw[beat] <= ram_m_rdata;
        beat     <= beat + 2'd1;
      end
      if (state == SLOT && go_c) begin
        dma_bytes    <= cur_bytes_c;
        dma_dst_addr <= slot_base + frm_len;
      end
      if (claim_c) in_frame <= 1'b1;

      // Claim and release in the same cycle cancel out.
      if (claim_c && !ret_c)
        free_cnt <= free_cnt - CNT_W'(1);
      else if (!claim_c && ret_c && free_cnt != CNT_W'(NSLOT))
        free_cnt <= free_cnt + CNT_W'(1);

      if (state == DMA_WAIT && rpt_valid) frm_len <= frm_len + dma_bytes;

      if (frame_done_c) begin
        frm_len  <= '0;
        in_frame <= 1'b0;
        slot_idx <= slot_idx + SLOT_W'(1);
        slot_base <= (slot_idx == SLOT_W'(NSLOT - 1)) ? BUF_BASE
                                                      : slot_base + 16'(SLOT_BYTES);
      end
    end
  end

  // Inputs carried for interface completeness only.
  logic unused_ok;
  assign unused_ok = ^{cmd_s_tdata[31:16], ram_m_rid, ram_m_rresp, ram_m_bid, ram_m_bresp,
                       rpt_src_addr, rpt_dst_addr, rpt_bytes, frm_s_tdata, frm_s_tlast,
                       dw[2], dw[3]};

endmodule
